// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared bus encodings, FSM states and default divisors for the SPART driver
package spart_pkg;

   localparam logic [1:0] ADDR_BUF   = 2'b00;
   localparam logic [1:0] ADDR_STAT  = 2'b01;
   localparam logic [1:0] ADDR_DB_LO = 2'b10;
   localparam logic [1:0] ADDR_DB_HI = 2'b11;

   localparam logic [15:0] DEF_DB_CFG0 = 16'h12C0;
   localparam logic [15:0] DEF_DB_CFG1 = 16'h2580;
   localparam logic [15:0] DEF_DB_CFG2 = 16'h4B00;
   localparam logic [15:0] DEF_DB_CFG3 = 16'h9600;

   typedef enum logic [2:0] {
      LOAD_LO  = 3'd0,
      LOAD_HI  = 3'd1,
      IDLE     = 3'd2,
      READ     = 3'd3,
      WAIT_TBR = 3'd4,
      WRITE    = 3'd5
   } state_t;

endpackage

// File: rtl/spart_driver.sv
// rtl/spart_driver.sv - programs the SPART baud divisor, then echoes every received byte
// The state names the access to issue at the next edge (load states) or the access on the bus now.
module spart_driver
   import spart_pkg::*;
#(
   parameter logic [15:0] DB_CFG0 = DEF_DB_CFG0,
   parameter logic [15:0] DB_CFG1 = DEF_DB_CFG1,
   parameter logic [15:0] DB_CFG2 = DEF_DB_CFG2,
   parameter logic [15:0] DB_CFG3 = DEF_DB_CFG3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] br_cfg,
   input  logic       rda,
   input  logic       tbr,
   output logic       iocs,
   output logic       iorw,
   output logic [1:0] ioaddr,
   output logic [7:0] data_out,
   input  logic [7:0] data_in,
   output logic [7:0] echo_cnt
);

   state_t      state;
   logic [1:0]  br_cfg_q;
   logic [7:0]  hold_byte;
   logic [15:0] db;
   logic        cfg_changed;

   always_comb begin
      db = DB_CFG0;
      case (br_cfg_q)
         2'b00:   db = DB_CFG0;
         2'b01:   db = DB_CFG1;
         2'b10:   db = DB_CFG2;
         default: db = DB_CFG3;
      endcase
   end

   assign cfg_changed = (br_cfg != br_cfg_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LOAD_LO;
         iocs      <= 1'b0;
         iorw      <= 1'b1;
         ioaddr    <= ADDR_BUF;
         data_out  <= 8'h00;
         hold_byte <= 8'h00;
         echo_cnt  <= 8'h00;
         br_cfg_q  <= br_cfg;
      end else begin
         // Idle bus values unless a case below issues an access; data_out holds.
         iocs   <= 1'b0;
         iorw   <= 1'b1;
         ioaddr <= ADDR_BUF;
         case (state)
            LOAD_LO: begin
               iocs     <= 1'b1;
               iorw     <= 1'b0;
               ioaddr   <= ADDR_DB_LO;
               data_out <= db[7:0];
               state    <= LOAD_HI;
            end
            LOAD_HI: begin
               iocs     <= 1'b1;
               iorw     <= 1'b0;
               ioaddr   <= ADDR_DB_HI;
               data_out <= db[15:8];
               state    <= IDLE;
            end
            IDLE: begin
               if (cfg_changed) begin
                  br_cfg_q <= br_cfg;
                  state    <= LOAD_LO;
               end else if (rda) begin
                  iocs  <= 1'b1;
                  state <= READ;
               end
            end
            READ: begin
               hold_byte <= data_in;
               state     <= WAIT_TBR;
            end
            WAIT_TBR: begin
               // A baud change abandons the held byte.
               if (cfg_changed) begin
                  br_cfg_q <= br_cfg;
                  state    <= LOAD_LO;
               end else if (tbr) begin
                  iocs     <= 1'b1;
                  iorw     <= 1'b0;
                  data_out <= hold_byte;
                  state    <= WRITE;
               end
            end
            WRITE: begin
               echo_cnt <= echo_cnt + 8'd1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/spart_driver.md
Name: spart_driver

Overview:
- Bus-master state machine that sits directly upstream of the SPART (baud_rate_gen + tx + rx) inside top_level.
- After reset, and whenever br_cfg changes, it programs the 16-bit baud divisor buffer (DB) over the SPART I/O bus.
- It then runs an echo loop: when the SPART has a received byte, it reads it, waits for the transmit buffer to be ready, and writes the byte back for transmission.
- This is the loopback the top_level bench exercises.

Parameters:
- DB_CFG0, 16'h12C0, DB value loaded for br_cfg=00 (4800).
- DB_CFG1, 16'h2580, DB value loaded for br_cfg=01 (9600).
- DB_CFG2, 16'h4B00, DB value loaded for br_cfg=10 (19200).
- DB_CFG3, 16'h9600, DB value loaded for br_cfg=11 (38400).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- br_cfg  in  2  baud select from DIP switches.
- rda  in  1  SPART receive-data-available.
- tbr  in  1  SPART transmit-buffer-ready.
- iocs  out  1  SPART chip select; one cycle per bus access.
- iorw  out  1  1 = read, 0 = write.
- ioaddr  out  2  00 = TX/RX buffer, 01 = status, 10 = DB low, 11 = DB high.
- data_out  out  8  write data to SPART.
- data_in  in  8  read data from SPART; valid in the same cycle as a read access.
- echo_cnt  out  8  count of bytes echoed; wraps.

Behaviour:
- Reset (rst=1 at posedge):
  - state <= LOAD_LO; iocs=0, iorw=1, ioaddr=00, data_out=00.
  - hold_byte=00, echo_cnt=00, br_cfg_q <= br_cfg.
  - All outputs are registered.
- Divisor select: a combinational mux picks DB_CFGn from br_cfg_q.
- States, one bus access per cycle; iocs is high only in LOAD_LO, LOAD_HI, READ and WRITE:
  - LOAD_LO: iocs=1, iorw=0, ioaddr=10, data_out=DB[7:0] -> LOAD_HI.
  - LOAD_HI: iocs=1, iorw=0, ioaddr=11, data_out=DB[15:8] -> IDLE.
  - IDLE: iocs=0. If rda=1 -> READ, else stay.
  - READ: iocs=1, iorw=1, ioaddr=00; hold_byte <= data_in at the end of this cycle -> WAIT_TBR.
  - WAIT_TBR: iocs=0. If tbr=1 -> WRITE, else stay; no timeout.
  - WRITE: iocs=1, iorw=0, ioaddr=00, data_out=hold_byte; echo_cnt <= echo_cnt+1 (mod 256) -> IDLE.
- Latency:
  - Reset deassert to LOAD_LO access: 1 cycle. DB fully loaded 2 cycles after reset deasserts.
  - rda seen in IDLE -> READ access on the next cycle.
  - Minimum rda-to-WRITE is 3 cycles, when tbr is already 1.
- Back-pressure: a new byte is never read while hold_byte is pending. rda is ignored outside IDLE; the SPART keeps rda asserted until the read.
- br_cfg change:
  - br_cfg_q is compared every cycle.
  - If br_cfg != br_cfg_q in IDLE or WAIT_TBR: br_cfg_q <= br_cfg, state <= LOAD_LO. A pending hold_byte is discarded and echo_cnt is not incremented.
  - If the change occurs in LOAD_LO, LOAD_HI, READ or WRITE: the current access completes, and the change is taken on the following cycle. In LOAD_LO it is taken after LOAD_HI.
- Simultaneous rda and br_cfg change in IDLE: re-init wins; the byte is read after reload.
- Reset mid-access: rst dominates everything; iocs drops on the next edge.
- Bus idle values when iocs=0: iorw=1, ioaddr=00, data_out holds its last value.

Decomposition:
- Shared package spart_pkg:
  - ioaddr encodings: ADDR_BUF=2'b00, ADDR_STAT=2'b01, ADDR_DB_LO=2'b10, ADDR_DB_HI=2'b11.
  - State encoding: 3-bit; LOAD_LO, LOAD_HI, IDLE, READ, WAIT_TBR, WRITE.
  - Default DB constants.
- Single module. No sub-module; the divisor mux is inline.

Test Plan:
1. Reset then br_cfg=01 -> cycle 1 after rst falls: iocs=1, iorw=0, ioaddr=10, data_out=80; cycle 2: ioaddr=11, data_out=25; cycle 3: iocs=0.
2. Repeat scenario 1 for br_cfg=00, 10 and 11 -> DB byte pairs C0/12, 00/4B and 00/96 respectively.
3. In IDLE, rda=1 with data_in=8'h40 and tbr=1 -> READ access next cycle; WRITE access with data_out=40 at 3 cycles; echo_cnt=1.
4. rda=1 with data_in=8'hA5 and tbr held 0 for 20 cycles -> stays in WAIT_TBR with iocs=0. When tbr rises -> one WRITE of A5 on the next cycle. A second rda pulse during the wait causes no extra READ.
5. Change br_cfg 01->11 while in WAIT_TBR -> LOAD_LO/LOAD_HI with bytes 00/96; no WRITE occurs; echo_cnt unchanged.
6. Assert rst during a WRITE cycle -> next cycle iocs=0 and echo_cnt=0, then the reload sequence starts.
7. Integrate with rx/tx models at each br_cfg: byte 8'h40 is echoed end-to-end.
8. Force echo_cnt to 255 and echo one byte -> wraps to 0.
